// File: rtl/timer_counter_ctrl_if.sv
// Button inputs and one-hot display values exchanged between the
// timer/counter controller and its environment.
interface timer_counter_ctrl_if;
    localparam int unsigned VAL_W = 21;

    logic             btn_start;
    logic             btn_count;
    logic [VAL_W-1:0] timer_out;
    logic [VAL_W-1:0] count_out;
    logic             running;

    modport master (
        output btn_start,
        output btn_count,
        input  timer_out,
        input  count_out,
        input  running
    );

    modport slave (
        input  btn_start,
        input  btn_count,
        output timer_out,
        output count_out,
        output running
    );
endinterface

// File: rtl/timer_counter_ctrl.sv
// Debounced start/count buttons driving a 0..20 second timer and a 0..20
// press counter, both presented one-hot to the display stage.
module timer_counter_ctrl #(
    parameter int unsigned CNT_1S   = 100_000_000,
    parameter int unsigned DEBOUNCE = 2_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    timer_counter_ctrl_if.slave  bus
);
    localparam int unsigned VAL_W  = 21;
    localparam int unsigned PCNT_W = (CNT_1S > 1) ? $clog2(CNT_1S) : 1;
    localparam int unsigned DB_W   = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Button path; index 0 is start, index 1 is count
    logic [1:0]            raw;
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            db_q, db_d;
    logic [1:0]            db_prev_q, db_prev_d;
    logic [1:0][DB_W-1:0]  stab_q, stab_d;
    logic [1:0]            pulse;
    logic                  start_p;
    logic                  count_p;

    state_e                state_q, state_d;
    logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
    logic [VAL_W-1:0]      timer_q, timer_d;
    logic [VAL_W-1:0]      count_q, count_d;
    logic                  running_q, running_d;
    logic                  tick;

    // Returns {next db, next stability count} for one button.
    function automatic logic [DB_W:0] db_step(input logic            s2,
                                              input logic            db,
                                              input logic [DB_W-1:0] stab);
        logic [DB_W:0] r;
        r = {db, stab + DB_W'(1)};
        if (s2 == db) begin
            r = {db, {DB_W{1'b0}}};
        end else if (stab == DB_W'(DEBOUNCE - 1)) begin
            r = {s2, {DB_W{1'b0}}};
        end
        return r;
    endfunction

    assign raw = {bus.btn_count, bus.btn_start};

    always_comb begin
        sync1_d   = raw;
        sync2_d   = sync1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        stab_d    = stab_q;
        {db_d[0], stab_d[0]} = db_step(sync2_q[0], db_q[0], stab_q[0]);
        {db_d[1], stab_d[1]} = db_step(sync2_q[1], db_q[1], stab_q[1]);
    end

    // One-cycle pulse in the cycle the debounced level has just risen
    assign pulse   = db_q & ~db_prev_q;
    assign start_p = pulse[0];
    assign count_p = pulse[1];

    assign tick = (state_q == RUN) && (pcnt_q == PCNT_W'(CNT_1S - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_p) state_d = RUN;
            RUN: begin
                if (tick && timer_q[VAL_W-2]) begin
                    state_d = DONE;
                end else if (start_p) begin
                    state_d = PAUSE;
                end
            end
            PAUSE:   if (start_p) state_d = RUN;
            DONE:    if (start_p) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates; count press is ignored when start fires the same cycle
    always_comb begin
        pcnt_d    = pcnt_q;
        timer_d   = timer_q;
        count_d   = count_q;
        running_d = (state_d == RUN);
        case (state_q)
            IDLE: begin
                if (start_p) pcnt_d = '0;
            end
            RUN: begin
                pcnt_d = tick ? '0 : pcnt_q + PCNT_W'(1);
                if (tick) timer_d = timer_q << 1;
                if (count_p && !start_p) begin
                    count_d = count_q[VAL_W-1] ? VAL_W'(1) : count_q << 1;
                end
            end
            DONE: begin
                if (start_p) begin
                    pcnt_d  = '0;
                    timer_d = VAL_W'(1);
                    count_d = VAL_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            stab_q    <= '0;
            pcnt_q    <= '0;
            timer_q   <= VAL_W'(1);
            count_q   <= VAL_W'(1);
            running_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            stab_q    <= stab_d;
            pcnt_q    <= pcnt_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            running_q <= running_d;
        end
    end

    assign bus.timer_out = timer_q;
    assign bus.count_out = count_q;
    assign bus.running   = running_q;
endmodule

// File: tb/tb_timer_counter_ctrl.sv
// Directed and randomized checks of timer_counter_ctrl against a
// cycle-level behavioural model using integer timer/count values.
module tb_timer_counter_ctrl;
    localparam int CNT = 10;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    timer_counter_ctrl_if bus ();

    timer_counter_ctrl #(
        .CNT_1S   (CNT),
        .DEBOUNCE (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: state 0=IDLE 1=RUN 2=PAUSE 3=DONE; timer/count as plain integers
    int m_state = 0;
    int m_t     = 0;
    int m_c     = 0;
    int m_pc    = 0;
    bit m_s1[2];
    bit m_s2[2];
    bit m_db[2];
    bit m_dbp[2];
    int m_len[2];

    function automatic logic [20:0] oh(input int v);
        return 21'(1) << v;
    endfunction

    task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit sp, cp, tk;
        bit raw[2];
        raw[0] = bus.btn_start;
        raw[1] = bus.btn_count;
        if (rst) begin
            m_state = 0; m_t = 0; m_c = 0; m_pc = 0;
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_dbp[i] = 0; m_len[i] = 0;
            end
            return;
        end
        sp = m_db[0] && !m_dbp[0];
        cp = m_db[1] && !m_dbp[1];
        tk = (m_state == 1) && (m_pc == CNT - 1);
        for (int i = 0; i < 2; i++) begin
            m_dbp[i] = m_db[i];
            if (m_s2[i] != m_db[i]) begin
                m_len[i]++;
                if (m_len[i] == DEB) begin
                    m_db[i]  = m_s2[i];
                    m_len[i] = 0;
                end
            end else begin
                m_len[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
        case (m_state)
            0: if (sp) begin m_state = 1; m_pc = 0; end
            1: begin
                if (cp && !sp) m_c = (m_c + 1) % 21;
                if (tk) begin
                    m_pc = 0;
                    m_t  = m_t + 1;
                    if (m_t == 20) m_state = 3;
                    else if (sp) m_state = 2;
                end else begin
                    m_pc = m_pc + 1;
                    if (sp) m_state = 2;
                end
            end
            2: if (sp) m_state = 1;
            default: if (sp) begin m_state = 1; m_t = 0; m_c = 0; m_pc = 0; end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("timer_model", bus.timer_out, oh(m_t));
        chk("count_model", bus.count_out, oh(m_c));
        chk("running_model", {20'b0, bus.running}, {20'b0, m_state == 1});
        chk("timer_onehot", {20'b0, $onehot(bus.timer_out)}, 21'h1);
        chk("count_onehot", {20'b0, $onehot(bus.count_out)}, 21'h1);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic press(input bit which, input int hold, input int low);
        if (which) bus.btn_count = 1'b1; else bus.btn_start = 1'b1;
        steps(hold);
        if (which) bus.btn_count = 1'b0; else bus.btn_start = 1'b0;
        steps(low);
    endtask

    // Hold start until running rises (bounded), then release.
    task automatic start_until_running();
        int g;
        g = 0;
        bus.btn_start = 1'b1;
        while (bus.running !== 1'b1 && g < 20) begin
            step();
            g++;
        end
        chk("start_latency", {20'b0, bus.running}, 21'h1);
        bus.btn_start = 1'b0;
    endtask

    initial begin
        int n;
        int h;
        int t0;
        int c0;
        bus.btn_start = 1'b0;
        bus.btn_count = 1'b0;
        rst = 1'b1;
        steps(3);
        chk("reset_timer", bus.timer_out, 21'h1);
        chk("reset_count", bus.count_out, 21'h1);
        chk("reset_running", {20'b0, bus.running}, 21'h0);
        rst = 1'b0;
        steps(2);

        // Short bounces alone must not start the timer
        repeat (6) begin
            bus.btn_start = 1'b1;
            steps(int'($urandom_range(1, 3)));
            bus.btn_start = 1'b0;
            steps(int'($urandom_range(1, 3)));
        end
        steps(10);
        chk("bounce_reject", {20'b0, bus.running}, 21'h0);
        bus.btn_start = 1'b1;
        steps(20);
        bus.btn_start = 1'b0;
        steps(10);
        chk("single_start_pulse", {20'b0, bus.running}, 21'h1);

        // Reset in the middle of RUN
        press(1'b1, 5, 5);
        chk("count_before_reset", bus.count_out, 21'h2);
        rst = 1'b1;
        steps(3);
        chk("midrun_reset_timer", bus.timer_out, 21'h1);
        chk("midrun_reset_count", bus.count_out, 21'h1);
        chk("midrun_reset_running", {20'b0, bus.running}, 21'h0);
        rst = 1'b0;
        steps(2);

        // Full 20-second run
        start_until_running();
        press(1'b1, 5, 5);
        steps(189);
        chk("timer_at_199", bus.timer_out, 21'h80000);
        chk("running_at_199", {20'b0, bus.running}, 21'h1);
        step();
        chk("timer_done_200", bus.timer_out, 21'h100000);
        chk("running_done", {20'b0, bus.running}, 21'h0);
        steps(100);
        chk("done_frozen_timer", bus.timer_out, 21'h100000);
        chk("done_frozen_count", bus.count_out, 21'h2);

        // Start from DONE clears both values
        start_until_running();
        chk("restart_timer", bus.timer_out, 21'h1);
        chk("restart_count", bus.count_out, 21'h1);

        // 21 presses wrap the count back to zero
        for (int i = 1; i <= 21; i++) begin
            press(1'b1, 4, 4);
            if (i == 20) chk("count_20", bus.count_out, 21'h100000);
        end
        chk("count_wrap", bus.count_out, 21'h1);
        chk("count_wrap_running", {20'b0, bus.running}, 21'h1);

        n = 0;
        while (bus.running !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        chk("reach_done", {20'b0, bus.running}, 21'h0);

        // Pause at 3 seconds, then resume with the remaining prescaler cycles
        start_until_running();
        n = 0;
        while (bus.timer_out !== 21'h8 && n < 60) begin
            step();
            n++;
        end
        chk("reach_timer_3", bus.timer_out, 21'h8);
        press(1'b0, 5, 50);
        chk("pause_hold_timer", bus.timer_out, 21'h8);
        chk("pause_running", {20'b0, bus.running}, 21'h0);
        press(1'b1, 5, 5);
        press(1'b1, 5, 5);
        chk("pause_count_gated", bus.count_out, 21'h1);
        start_until_running();
        h = m_pc;
        n = 0;
        while (bus.timer_out !== 21'h10 && n < 20) begin
            step();
            n++;
        end
        chk("resume_remaining", 21'(n), 21'(CNT - h));

        // Start and count in the same cycle: pause wins, count discarded
        press(1'b1, 4, 4);
        chk("count_before_collide", bus.count_out, 21'h2);
        bus.btn_start = 1'b1;
        bus.btn_count = 1'b1;
        steps(5);
        bus.btn_start = 1'b0;
        bus.btn_count = 1'b0;
        steps(10);
        chk("collide_pause", {20'b0, bus.running}, 21'h0);
        chk("collide_count", bus.count_out, 21'h2);

        // Count pulse landing on a tick cycle: both advance on one edge
        start_until_running();
        steps(4);
        n = 0;
        while (!(m_state == 1 && m_pc == 3) && n < 20) begin
            step();
            n++;
        end
        t0 = m_t;
        c0 = m_c;
        bus.btn_count = 1'b1;
        steps(4);
        bus.btn_count = 1'b0;
        steps(2);
        chk("tick_coll_timer_pre", bus.timer_out, oh(t0));
        chk("tick_coll_count_pre", bus.count_out, oh(c0));
        step();
        chk("tick_coll_timer", bus.timer_out, oh(t0 + 1));
        chk("tick_coll_count", bus.count_out, oh((c0 + 1) % 21));

        // Random button activity with occasional resets
        repeat (120) begin
            bus.btn_start = 1'($urandom_range(0, 1));
            bus.btn_count = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 29) == 0);
            steps(int'($urandom_range(1, 8)));
            rst = 1'b0;
        end
        bus.btn_start = 1'b0;
        bus.btn_count = 1'b0;
        steps(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
